// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the integer register file.
package regfile_pkg;

    // Register file control state: power-up sweep, normal operation, requested sweep
    typedef enum logic [1:0] {
        RF_INIT  = 2'd0,
        RF_RUN   = 2'd1,
        RF_CLEAR = 2'd2
    } rf_state_t;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_NRD   = 2;

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer for regfile_nport: walks ptr over registers 1..NREGS-1 writing
// zero after reset or on clr_req, and raises ready once the sweep has finished.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = RF_NREGS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_req,
    output rf_state_t                  state,
    output logic                       ready,
    output logic                       clr_we,
    output logic [$clog2(NREGS)-1:0]   clr_addr
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW-1:0] PTR_FIRST = AW'(1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(NREGS - 1);

    rf_state_t       state_reg, state_next;
    logic [AW-1:0]   ptr_reg,   ptr_next;
    logic            ready_reg, ready_next;

    // State, sweep pointer and ready flag; reset restarts the sweep at register 1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= RF_INIT;
            ptr_reg   <= PTR_FIRST;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            ready_reg <= ready_next;
        end
    end

    // Next-state logic: sweep until the last register is cleared, then run
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        ready_next = ready_reg;
        case (state_reg)
            RF_INIT, RF_CLEAR: begin
                // clr_req is ignored here: a sweep in progress never restarts
                ptr_next = ptr_reg + AW'(1);
                if (ptr_reg == PTR_LAST) begin
                    state_next = RF_RUN;
                    ptr_next   = PTR_FIRST;
                    ready_next = 1'b1;
                end
            end
            RF_RUN: begin
                if (clr_req) begin
                    state_next = RF_CLEAR;
                    ptr_next   = PTR_FIRST;
                    ready_next = 1'b0;
                end
            end
            default: begin
                state_next = RF_INIT;
                ptr_next   = PTR_FIRST;
                ready_next = 1'b0;
            end
        endcase
    end

    assign state    = state_reg;
    assign ready    = ready_reg;
    assign clr_we   = (state_reg != RF_RUN);
    assign clr_addr = ptr_reg;

endmodule

// File: rtl/regfile_nport.sv
// N-read-port integer register file with x0 hardwired to zero and a hardware
// clear sweep. Optional macro REGFILE_BYPASS_EN forwards same-cycle write data
// to matching read ports; without it reads see the old contents until the next cycle.
module regfile_nport
    import regfile_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = RF_NRD
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              we,
    input  logic [$clog2(NREGS)-1:0]          waddr,
    input  logic [XLEN-1:0]                   wdata,
    input  logic [NRD*$clog2(NREGS)-1:0]      raddr,
    output logic [NRD*XLEN-1:0]               rdata,
    input  logic                              clr_req,
    output logic                              ready,
    output logic                              wr_drop
);

    localparam int AW  = $clog2(NREGS);
    localparam int AW1 = AW + 1;
    // One extra bit keeps the range compare meaningful when NREGS is a power of two
    localparam logic [AW:0] NREGS_W = AW1'(NREGS);

    rf_state_t       state;
    logic            clr_we;
    logic [AW-1:0]   clr_addr;
    logic            waddr_ok;
    logic            user_we;
    logic            drop_now;
    logic            wr_drop_reg;

    logic [XLEN-1:0] mem [NREGS];

    regfile_clear_seq #(
        .NREGS (NREGS)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .state    (state),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign waddr_ok = ({1'b0, waddr} < NREGS_W);
    // A user write lands only in RUN, without a competing clear, to a real register
    assign user_we  = we && (state == RF_RUN) && !clr_req && waddr_ok && (waddr != '0);
    // Writes to x0 vanish silently; every other rejected write is reported
    assign drop_now = we && ((state != RF_RUN) || clr_req || !waddr_ok);

    // Report a discarded write one cycle after it was attempted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_drop_reg <= 1'b0;
        end else begin
            wr_drop_reg <= drop_now;
        end
    end

    assign wr_drop = wr_drop_reg;

    // Storage: the sweep owns the write port until it completes
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (user_we) begin
            mem[waddr] <= wdata;
        end
    end

    // Independent combinational read ports
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0] ra;
        logic          ra_ok;

        assign ra    = raddr[gi*AW +: AW];
        assign ra_ok = ready && (ra != '0) && ({1'b0, ra} < NREGS_W);

`ifdef REGFILE_BYPASS_EN
        logic fwd;
        assign fwd = user_we && (ra == waddr);
        assign rdata[gi*XLEN +: XLEN] = !ra_ok ? '0 : (fwd ? wdata : mem[ra]);
`else
        assign rdata[gi*XLEN +: XLEN] = ra_ok ? mem[ra] : '0;
`endif
    end

endmodule
